// File: rtl/digit_serial_add_pkg.sv
// digit_serial_add_pkg
//   Shared definitions for the digit-serial adder/subtractor:
//   - state_e      : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   - width_legal  : WIDTH/DIGIT legality test used at elaboration
//   - full_add     : single-bit full-adder cell, returns {carry, sum}
package digit_serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic bit width_legal(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/digit_serial_add_ripple_slice.sv
// ripple_slice
//   DIGIT-wide combinational ripple-carry adder built from full_add cells.
//   Ports:
//     x, y   in  [DIGIT]  addend digits
//     ci     in  1        carry into bit 0
//     sum    out [DIGIT]  digit sum
//     co     out 1        carry out of the top bit
//     c_msb  out 1        carry into the top bit (for overflow detection)
module ripple_slice
    import digit_serial_add_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign {c[i+1], sum[i]} = full_add(x[i], y[i], c[i]);
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_add.sv
// digit_serial_add
//   Multi-cycle adder/subtractor processing DIGIT bits per clock over
//   N = WIDTH/DIGIT cycles, with a carry register linking the digits.
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   synchronous active-high reset
//     start  in   request, accepted in IDLE or DONE
//     a, b   in   [WIDTH] operands, sampled with an accepted start
//     cin    in   carry-in for add (ignored for sub)
//     sub    in   0: a+b+cin, 1: a-b
//     s      out  [WIDTH] result, valid from done until next accepted start
//     cout   out  carry out of MSB (sub: 1 = no borrow)
//     ovf    out  signed overflow
//     busy   out  high while in RUN
//     done   out  one-cycle completion pulse
module digit_serial_add
    import digit_serial_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (!width_legal(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("digit_serial_add: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [31:0]        base;
    logic [DIGIT-1:0]   x_dig, y_dig, sum_dig;
    logic               co_dig, msb_dig;
    logic               last;

    // b is stored pre-inverted for subtraction, so the slice only ever adds.
    assign base  = 32'(idx_q) * 32'(DIGIT);
    assign x_dig = a_q[base +: DIGIT];
    assign y_dig = b_q[base +: DIGIT];
    assign last  = (idx_q == IDX_W'(N - 1));

    ripple_slice #(.DIGIT(DIGIT)) u_slice (
        .x     (x_dig),
        .y     (y_dig),
        .ci    (carry_q),
        .sum   (sum_dig),
        .co    (co_dig),
        .c_msb (msb_dig)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                s_d[base +: DIGIT] = sum_dig;
                carry_d            = co_dig;
                if (last) begin
                    state_d = ST_DONE;
                    cout_d  = co_dig;
                    // On the final digit the slice's top bit is bit WIDTH-1.
                    ovf_d   = co_dig ^ msb_dig;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_digit_serial_add.sv
// tb_digit_serial_add
//   Directed checks on an 8-bit/4-bit-digit instance, plus a random sweep of
//   three 32-bit instances (DIGIT = 1, 8, 32) against an arithmetic model.
module tb_digit_serial_add;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // 8-bit directed instance
    logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] s8;
    logic       cout8, ovf8, busy8, done8;

    digit_serial_add #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .s(s8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    // 32-bit sweep instances sharing stimulus
    logic        start32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] s32    [3];
    logic        cout32 [3];
    logic        ovf32  [3];
    logic        busy32 [3];
    logic        done32 [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 8 : 32;
        digit_serial_add #(.WIDTH(32), .DIGIT(DG)) u_dut (
            .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
            .s(s32[g]), .cout(cout32[g]), .ovf(ovf32[g]), .busy(busy32[g]), .done(done32[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Arithmetic reference: plain integer math on the operands' values.
    function automatic void ref_model(input int w, input longint unsigned ua, input longint unsigned ub,
                                      input bit c, input bit sb,
                                      output longint unsigned rs, output bit rc, output bit ro);
        longint unsigned mask;
        longint          sa, sbv, sr, lim;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(ua);
        sbv  = longint'(ub);
        if (((ua >> (w - 1)) & 1) != 0) sa  = sa  - (longint'(1) << w);
        if (((ub >> (w - 1)) & 1) != 0) sbv = sbv - (longint'(1) << w);
        lim = longint'(1) << (w - 1);
        if (!sb) begin
            rs = (ua + ub + longint'(c)) & mask;
            rc = (((ua + ub + longint'(c)) >> w) & 1) != 0;
            sr = sa + sbv + longint'(c);
        end else begin
            rs = (ua - ub) & mask;
            rc = (ua >= ub);
            sr = sa - sbv;
        end
        ro = (sr >= lim) || (sr < -lim);
    endfunction

    // One operation on the 8-bit instance; optional start re-pulse during RUN.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tc, input logic ts, input bit poke,
                       input logic [7:0] es, input logic ec, input logic eo);
        int lat, nd;
        logic [7:0] gs;
        logic gc, go;
        lat = 0; nd = 0; gs = '0; gc = 1'b0; go = 1'b0;
        @(negedge clk);
        a8 = ta; b8 = tb_v; cin8 = tc; sub8 = ts; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        if (poke) begin
            a8 = ~ta; b8 = 8'h33; cin8 = 1'b1; sub8 = ~ts; start8 = 1'b1;
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin
                nd++;
                if (lat == 0) begin
                    lat = k; gs = s8; gc = cout8; go = ovf8;
                end
            end
        end
        chk({tag, "_s"},    64'(gs),  64'(es));
        chk({tag, "_cout"}, 64'(gc),  64'(ec));
        chk({tag, "_ovf"},  64'(go),  64'(eo));
        chk({tag, "_lat"},  64'(lat), 64'd2);
        chk({tag, "_ndone"},64'(nd),  64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_s8",    64'(s8),    64'd0);
        chk("rst_cout8", 64'(cout8), 64'd0);
        chk("rst_ovf8",  64'(ovf8),  64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        for (int g = 0; g < 3; g++) begin
            chk("rst_s32",    64'(s32[g]),    64'd0);
            chk("rst_busy32", 64'(busy32[g]), 64'd0);
        end

        op8("ff_p_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("7f_p_01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("05_m_07", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        op8("cin_add", 8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 8'h47, 1'b0, 1'b0);
        op8("sub_cin", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
        op8("poke",    8'h21, 8'h43, 1'b0, 1'b0, 1'b1, 8'h64, 1'b0, 1'b0);

        // Back-to-back: start held in DONE starts the next op with no IDLE cycle.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_done1", 64'(done8), 64'd1);
        chk("b2b_s1",    64'(s8),    64'h03);
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        chk("b2b_busy",  64'(busy8), 64'd1);
        chk("b2b_nodone",64'(done8), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b_done2", 64'(done8), 64'd1);
        chk("b2b_s2",    64'(s8),    64'h30);

        // Leave nonzero outputs behind, then reset during the first RUN cycle.
        op8("pre_rst", 8'hC0, 8'hC0, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_s",    64'(s8),    64'd0);
        chk("mid_rst_cout", 64'(cout8), 64'd0);
        chk("mid_rst_busy", 64'(busy8), 64'd0);
        chk("mid_rst_done", 64'(done8), 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_idle", 64'(done8), 64'd0);
        op8("post_rst", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Random sweep on the 32-bit instances.
        for (int op = 0; op < 1000; op++) begin
            logic [31:0] ta, tb_v;
            logic tc, ts;
            longint unsigned es;
            bit ec, eo;
            int lat [3];
            int nd  [3];
            logic [31:0] gs [3];
            logic gc [3];
            logic go [3];
            ta = $urandom; tb_v = $urandom;
            tc = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ta   = 32'h7FFF_FFFF;
                1: tb_v = 32'h8000_0000;
                2: begin ta = 32'hFFFF_FFFF; tb_v = 32'h0000_0001; end
                3: tb_v = ta;
                default: ;
            endcase
            ref_model(32, longint'(ta), longint'(tb_v), tc, ts, es, ec, eo);
            for (int g = 0; g < 3; g++) begin
                lat[g] = 0; nd[g] = 0; gs[g] = '0; gc[g] = 1'b0; go[g] = 1'b0;
            end
            @(negedge clk);
            a32 = ta; b32 = tb_v; cin32 = tc; sub32 = ts; start32 = 1'b1;
            @(posedge clk); #1;
            start32 = 1'b0;
            for (int k = 1; k <= 36; k++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 3; g++) begin
                    if (done32[g]) begin
                        nd[g]++;
                        if (lat[g] == 0) begin
                            lat[g] = k; gs[g] = s32[g]; gc[g] = cout32[g]; go[g] = ovf32[g];
                        end
                    end
                end
            end
            for (int g = 0; g < 3; g++) begin
                int n_exp;
                n_exp = (g == 0) ? 32 : (g == 1) ? 4 : 1;
                chk($sformatf("rnd%0d_d%0d_s", op, g),    64'(gs[g]),  64'(es));
                chk($sformatf("rnd%0d_d%0d_cout", op, g), 64'(gc[g]),  64'(ec));
                chk($sformatf("rnd%0d_d%0d_ovf", op, g),  64'(go[g]),  64'(eo));
                chk($sformatf("rnd%0d_d%0d_lat", op, g),  64'(lat[g]), 64'(n_exp));
                chk($sformatf("rnd%0d_d%0d_nd", op, g),   64'(nd[g]),  64'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
